genbuf_rx_responder: RTL

- Receiver-side responder for the generalized-buffer (genbuf) interface: two receiver channels answer buffer requests (btor_req[i]) with acknowledges (rtob_ack[i]).
- Each channel honours the receiver-side protocol rules:
  - no ack without a prior-cycle request;
  - ack is held while the request is held;
  - ack is released after the request drops;
  - ack latency is bounded, so every request is eventually acknowledged.
- Words accepted from the buffer are queued in a shared local FIFO and drained by a downstream consumer.
- The block sits in the scheduling/synthesis benches as the concrete environment for buffer controllers.

---
 rtl/genbuf_rx_pkg.sv | 22 ++
 rtl/genbuf_rx_responder_if.sv | 41 ++++
 rtl/genbuf_rx_fifo.sv | 70 +++++++
 rtl/genbuf_rx_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/genbuf_rx_pkg.sv
// ----------------------------------------------------------------------------
// Module   : genbuf_rx_pkg
// Brief    : Shared types and widths for the genbuf receiver-side responder.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package genbuf_rx_pkg;

  localparam int c_num_ch = 2;
  localparam int c_lat_w  = 4;
  localparam int c_stat_w = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/genbuf_rx_responder_if.sv
// ----------------------------------------------------------------------------
// Module   : genbuf_rx_responder_if
// Brief    : Buffer-side request/ack and consumer-side FIFO head signals.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface genbuf_rx_responder_if #(
  parameter int DW = 8
);

  logic [1:0]    btor_req;
  logic [DW-1:0] buf_data;
  logic [1:0]    rtob_ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // master: the buffer and downstream consumer environment
  modport master (
    output btor_req,
    output buf_data,
    output out_ready,
    input  rtob_ack,
    input  out_valid,
    input  out_data
  );

  // slave: the responder itself
  modport slave (
    input  btor_req,
    input  buf_data,
    input  out_ready,
    output rtob_ack,
    output out_valid,
    output out_data
  );

endinterface

`default_nettype wire

// File: rtl/genbuf_rx_fifo.sv
// ----------------------------------------------------------------------------
// Module   : genbuf_rx_fifo
// Brief    : DEPTH x DW synchronous FIFO, simultaneous push/pop, no bypass.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module genbuf_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     push,
  input  wire  [DW-1:0]           push_data,
  input  wire                     pop,
  output logic [DW-1:0]           head_data,
  output logic                    head_valid,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int c_aw = $clog2(DEPTH);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  logic w_do_pop;
  logic w_do_push;
  logic w_full;

  assign w_full    = (r_count == (c_aw+1)'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data  = r_mem[r_rd_ptr];
  assign head_valid = (r_count != '0);
  assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/genbuf_rx_responder.sv
// ----------------------------------------------------------------------------
// Module   : genbuf_rx_responder
// Brief    : Two-channel genbuf receiver responder with shared local FIFO.
//            GENBUF_RX_STATS_EN enables per-channel completion counters.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module genbuf_rx_responder
  import genbuf_rx_pkg::*;
#(
  parameter int DW      = 8,
  parameter int ACK_LAT = 2,
  parameter int DEPTH   = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  genbuf_rx_responder_if.slave   bus,
  output logic                   proto_err,
  output logic [c_stat_w-1:0]    stat_cnt0,
  output logic [c_stat_w-1:0]    stat_cnt1
);

  localparam int                 c_cw      = $clog2(DEPTH) + 1;
  localparam logic [c_lat_w-1:0] c_ack_lat = c_lat_w'(ACK_LAT);

  logic [c_cw-1:0]                   w_count;
  logic                              w_fifo_valid;
  logic [DW-1:0]                     w_fifo_data;
  logic                              w_pop;
  logic [c_num_ch-1:0]               w_push;
  logic [c_num_ch-1:0]               w_in_wait;
  logic [c_num_ch-1:0]               w_drop;
  logic [c_num_ch-1:0]               w_ack;
  logic [1:0]                        w_reserved;
  logic [c_cw:0]                     w_need;
  logic                              w_slot_free;
  logic                              w_both;
  logic [c_num_ch-1:0][c_stat_w-1:0] w_stat;
  logic                              r_proto_err;

  assign w_pop      = w_fifo_valid && bus.out_ready;
  assign w_both     = &bus.btor_req;
  assign w_reserved = {1'b0, w_in_wait[0]} + {1'b0, w_in_wait[1]};

  // Occupancy after this cycle's pop plus slots already promised to WAIT channels.
  assign w_need      = {1'b0, w_count} - (c_cw+1)'(w_pop) + (c_cw+1)'(w_reserved);
  assign w_slot_free = (w_need < (c_cw+1)'(DEPTH));

  for (genvar i = 0; i < c_num_ch; i++) begin : g_ch
    rx_state_t          r_state;
    logic [c_lat_w-1:0] r_cnt;
    logic               r_ack;
    logic               w_go;
    logic               w_start;
    logic               w_fire;

    // Channel 1 freezes whenever both requests collide; channel 0 wins.
    assign w_go         = (i == 0) || !w_both;
    assign w_start      = w_go && (r_state == IDLE) && bus.btor_req[i] && w_slot_free;
    assign w_fire       = w_go && (r_state == WAIT) && bus.btor_req[i] && (r_cnt == '0);
    assign w_push[i]    = w_fire || (w_start && (c_ack_lat == '0));
    assign w_drop[i]    = (r_state == WAIT) && !bus.btor_req[i];
    assign w_in_wait[i] = (r_state == WAIT);
    assign w_ack[i]     = r_ack;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_ack   <= 1'b0;
      end else if (w_go) begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_cnt <= c_ack_lat;
              if (c_ack_lat == '0) begin
                r_state <= ACK;
                r_ack   <= 1'b1;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (!bus.btor_req[i]) begin
              r_state <= IDLE;
            end else if (r_cnt == '0) begin
              r_state <= ACK;
              r_ack   <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_lat_w'(1);
            end
          end
          ACK: begin
            if (!bus.btor_req[i]) begin
              r_state <= IDLE;
              r_ack   <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        endcase
      end
    end

`ifdef GENBUF_RX_STATS_EN
    logic [c_stat_w-1:0] r_stat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stat <= '0;
      end else if (w_go && (r_state == ACK) && !bus.btor_req[i] && (r_stat != '1)) begin
        r_stat <= r_stat + c_stat_w'(1);
      end
    end

    assign w_stat[i] = r_stat;
`else
    assign w_stat[i] = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_both || (|w_drop)) begin
      r_proto_err <= 1'b1;
    end
  end

  genbuf_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (|w_push),
    .push_data  (bus.buf_data),
    .pop        (w_pop),
    .head_data  (w_fifo_data),
    .head_valid (w_fifo_valid),
    .count      (w_count)
  );

  assign bus.rtob_ack  = w_ack;
  assign bus.out_valid = w_fifo_valid;
  assign bus.out_data  = w_fifo_data;
  assign proto_err     = r_proto_err;
  assign stat_cnt0     = w_stat[0];
  assign stat_cnt1     = w_stat[1];

endmodule

`default_nettype wire
